// File: rtl/ppfifo_checker_sink.sv
// Ping-pong FIFO write-port responder: offers two buffers, accepts bursts,
// models the drain back to empty and checks an incrementing data pattern.
module ppfifo_checker_sink #(
  parameter int unsigned BUFFER_DEPTH  = 2048,
  parameter int unsigned DRAIN_LATENCY = 4,
  parameter logic [31:0] START_VALUE   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        clear,
  output logic [1:0]  ready,
  input  logic [1:0]  activate,
  output logic [23:0] size,
  input  logic [31:0] data,
  input  logic        strobe,
  output logic [31:0] total_count,
  output logic [23:0] last_xfer_count,
  output logic        data_error,
  output logic [15:0] mismatch_count,
  output logic [31:0] first_expected,
  output logic [31:0] first_actual,
  output logic        protocol_error,
  output logic        busy
);

  localparam int unsigned SW = 24;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 16;
  localparam int unsigned CW = $clog2(DRAIN_LATENCY + 1);

  typedef enum logic [1:0] {ST_EMPTY, ST_OWNED, ST_DRAIN} buf_state_e;

  buf_state_e       state_q [2];
  buf_state_e       state_d [2];
  logic [CW-1:0]    drain_q [2];
  logic [CW-1:0]    drain_d [2];
  logic [SW-1:0]    wcnt_q  [2];
  logic [SW-1:0]    wcnt_d  [2];

  logic [1:0]       ready_q, ready_d;
  logic [1:0]       act_prev_q, act_prev_d;
  logic [DW-1:0]    expected_q, expected_d;
  logic [DW-1:0]    total_q, total_d;
  logic [SW-1:0]    last_q, last_d;
  logic             data_error_q, data_error_d;
  logic [MW-1:0]    mismatch_q, mismatch_d;
  logic [DW-1:0]    first_exp_q, first_exp_d;
  logic [DW-1:0]    first_act_q, first_act_d;
  logic             proto_q, proto_d;

  logic [1:0]       own_act;
  logic             both_act;
  logic             one_owner;
  logic             sel;
  logic             sel_full;
  logic             accept;
  logic             viol;

  // Buffer FSMs, word acceptance, pattern check and handshake checks
  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    wcnt_d       = wcnt_q;
    ready_d      = ready_q;
    act_prev_d   = activate;
    expected_d   = expected_q;
    total_d      = total_q;
    last_d       = last_q;
    data_error_d = data_error_q;
    mismatch_d   = mismatch_q;
    first_exp_d  = first_exp_q;
    first_act_d  = first_act_q;
    proto_d      = proto_q;

    for (int i = 0; i < 2; i++) begin
      own_act[i] = (state_q[i] == ST_OWNED) && activate[i];
    end
    both_act  = (activate == 2'b11);
    one_owner = (own_act == 2'b01) || (own_act == 2'b10);
    sel       = own_act[1];
    sel_full  = (wcnt_q[sel] >= SW'(BUFFER_DEPTH));
    accept    = strobe && one_owner && !both_act && !sel_full && !clear;
    viol      = both_act || (strobe && (!one_owner || sel_full)) ||
                (|(activate & ~act_prev_q & ~ready_q));

    for (int i = 0; i < 2; i++) begin
      case (state_q[i])
        ST_EMPTY: begin
          if (activate[i] && ready_q[i] && !both_act) begin
            state_d[i] = ST_OWNED;
            wcnt_d[i]  = '0;
          end
        end
        ST_OWNED: begin
          if (!activate[i]) begin
            state_d[i] = ST_DRAIN;
            drain_d[i] = CW'(DRAIN_LATENCY);
            last_d     = wcnt_q[i];
          end
        end
        ST_DRAIN: begin
          if (drain_q[i] == CW'(1)) state_d[i] = ST_EMPTY;
          else                      drain_d[i] = drain_q[i] - CW'(1);
        end
        default: state_d[i] = ST_EMPTY;
      endcase
      if (accept && (sel == 1'(i))) wcnt_d[i] = wcnt_q[i] + SW'(1);
      ready_d[i] = (state_d[i] == ST_EMPTY) && enable;
    end

    if (accept) begin
      expected_d = expected_q + DW'(1);
      total_d    = total_q + DW'(1);
      if (data != expected_q) begin
        data_error_d = 1'b1;
        if (mismatch_q != '1) mismatch_d = mismatch_q + MW'(1);
        if (mismatch_q == '0) begin
          first_exp_d = expected_q;
          first_act_d = data;
        end
      end
    end
    if (viol) proto_d = 1'b1;

    // Clear dominates everything except the buffer state machines
    if (clear) begin
      expected_d   = START_VALUE;
      total_d      = '0;
      last_d       = '0;
      data_error_d = 1'b0;
      mismatch_d   = '0;
      first_exp_d  = '0;
      first_act_d  = '0;
      proto_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= ST_EMPTY;
        drain_q[i] <= '0;
        wcnt_q[i]  <= '0;
      end
      ready_q      <= '0;
      act_prev_q   <= '0;
      expected_q   <= START_VALUE;
      total_q      <= '0;
      last_q       <= '0;
      data_error_q <= 1'b0;
      mismatch_q   <= '0;
      first_exp_q  <= '0;
      first_act_q  <= '0;
      proto_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      wcnt_q       <= wcnt_d;
      ready_q      <= ready_d;
      act_prev_q   <= act_prev_d;
      expected_q   <= expected_d;
      total_q      <= total_d;
      last_q       <= last_d;
      data_error_q <= data_error_d;
      mismatch_q   <= mismatch_d;
      first_exp_q  <= first_exp_d;
      first_act_q  <= first_act_d;
      proto_q      <= proto_d;
    end
  end

  assign ready           = ready_q;
  assign size            = SW'(BUFFER_DEPTH);
  assign total_count     = total_q;
  assign last_xfer_count = last_q;
  assign data_error      = data_error_q;
  assign mismatch_count  = mismatch_q;
  assign first_expected  = first_exp_q;
  assign first_actual    = first_act_q;
  assign protocol_error  = proto_q;
  assign busy            = (state_q[0] != ST_EMPTY) || (state_q[1] != ST_EMPTY);

endmodule

// File: tb/tb_ppfifo_checker_sink.sv
// Directed bench for ppfifo_checker_sink: bursts, ping-pong, corruption,
// overflow, handshake abuse, clear and asynchronous reset.
module tb_ppfifo_checker_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clear;
  logic [1:0]  ready;
  logic [1:0]  activate;
  logic [23:0] size;
  logic [31:0] data;
  logic        strobe;
  logic [31:0] total_count;
  logic [23:0] last_xfer_count;
  logic        data_error;
  logic [15:0] mismatch_count;
  logic [31:0] first_expected;
  logic [31:0] first_actual;
  logic        protocol_error;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ppfifo_checker_sink dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .ready(ready),
    .activate(activate), .size(size), .data(data), .strobe(strobe),
    .total_count(total_count), .last_xfer_count(last_xfer_count),
    .data_error(data_error), .mismatch_count(mismatch_count),
    .first_expected(first_expected), .first_actual(first_actual),
    .protocol_error(protocol_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stimulus only: own buffer b, send n words base.., word bad_idx replaced by DEAD
  task automatic run_burst(input int b, input int n, input int base, input int bad_idx);
    @(negedge clk);
    activate[b] = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      strobe = 1'b1;
      data   = (i == bad_idx) ? 32'hDEAD : 32'(base + i);
    end
    @(negedge clk);
    strobe   = 1'b0;
    data     = '0;
    activate = 2'b00;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %0b exp 0", ready); end
    checks++; if (size !== 24'd2048) begin errors++; $display("FAIL reset_size got %0d exp 2048", size); end
    checks++; if (total_count !== 32'd0 || last_xfer_count !== 24'd0 || mismatch_count !== 16'd0) begin
      errors++; $display("FAIL reset_counts got %0d/%0d/%0d exp 0", total_count, last_xfer_count, mismatch_count); end
    checks++; if (data_error !== 1'b0 || protocol_error !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_flags got %0b%0b%0b exp 000", data_error, protocol_error, busy); end
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 2'b11) begin errors++; $display("FAIL offer_both got %0b exp 11", ready); end
  endtask

  task automatic test_single_burst();
    run_burst(0, 2048, 0, -1);
    checks++; if (busy !== 1'b1 || ready[0] !== 1'b0) begin
      errors++; $display("FAIL owned_busy got busy=%0b ready0=%0b exp 1/0", busy, ready[0]); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (ready[0] !== 1'b0) begin errors++; $display("FAIL drain_low k=%0d got %0b exp 0", k, ready[0]); end
    end
    @(negedge clk);
    checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL drain_done got %0b exp 1", ready[0]); end
    checks++; if (total_count !== 32'd2048) begin errors++; $display("FAIL burst_total got %0d exp 2048", total_count); end
    checks++; if (last_xfer_count !== 24'd2048) begin errors++; $display("FAIL burst_last got %0d exp 2048", last_xfer_count); end
    checks++; if (data_error !== 1'b0 || protocol_error !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL burst_flags got %0b%0b%0b exp 000", data_error, protocol_error, busy); end
  endtask

  task automatic test_ping_pong();
    pulse_clear();
    for (int n = 0; n < 4; n++) begin
      run_burst(n % 2, 100, n * 100, -1);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        checks++; if (ready[n % 2] !== 1'b0) begin errors++; $display("FAIL pp_drain_low n=%0d k=%0d got 1 exp 0", n, k); end
      end
      @(negedge clk);
      checks++; if (ready !== 2'b11) begin errors++; $display("FAIL pp_ready n=%0d got %0b exp 11", n, ready); end
    end
    checks++; if (total_count !== 32'd400) begin errors++; $display("FAIL pp_total got %0d exp 400", total_count); end
    checks++; if (last_xfer_count !== 24'd100) begin errors++; $display("FAIL pp_last got %0d exp 100", last_xfer_count); end
    checks++; if (data_error !== 1'b0 || protocol_error !== 1'b0) begin
      errors++; $display("FAIL pp_flags got %0b%0b exp 00", data_error, protocol_error); end
  endtask

  task automatic test_corruption();
    pulse_clear();
    run_burst(0, 20, 0, 10);
    repeat (6) @(negedge clk);
    checks++; if (data_error !== 1'b1) begin errors++; $display("FAIL corr_flag got %0b exp 1", data_error); end
    checks++; if (mismatch_count !== 16'd1) begin errors++; $display("FAIL corr_count got %0d exp 1", mismatch_count); end
    checks++; if (first_expected !== 32'd10) begin errors++; $display("FAIL corr_first_exp got %0h exp a", first_expected); end
    checks++; if (first_actual !== 32'hDEAD) begin errors++; $display("FAIL corr_first_act got %0h exp dead", first_actual); end
    checks++; if (total_count !== 32'd20 || protocol_error !== 1'b0) begin
      errors++; $display("FAIL corr_total got %0d/%0b exp 20/0", total_count, protocol_error); end
  endtask

  task automatic test_overflow();
    pulse_clear();
    run_burst(0, 2049, 0, -1);
    repeat (6) @(negedge clk);
    checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL ovf_proto got %0b exp 1", protocol_error); end
    checks++; if (total_count !== 32'd2048 || last_xfer_count !== 24'd2048) begin
      errors++; $display("FAIL ovf_counts got %0d/%0d exp 2048/2048", total_count, last_xfer_count); end
    checks++; if (data_error !== 1'b0) begin errors++; $display("FAIL ovf_data got %0b exp 0", data_error); end
    pulse_clear();
    strobe = 1'b1;
    data   = 32'd0;
    @(negedge clk);
    strobe = 1'b0;
    @(negedge clk);
    checks++; if (protocol_error !== 1'b1 || total_count !== 32'd0) begin
      errors++; $display("FAIL orphan got proto=%0b total=%0d exp 1/0", protocol_error, total_count); end
  endtask

  task automatic test_handshake();
    pulse_clear();
    activate = 2'b11;
    @(negedge clk);
    activate = 2'b00;
    checks++; if (protocol_error !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL both_act got proto=%0b busy=%0b exp 1/0", protocol_error, busy); end
    pulse_clear();
    enable = 1'b0;
    @(negedge clk);
    activate = 2'b10;
    @(negedge clk);
    activate = 2'b00;
    checks++; if (protocol_error !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL act_not_ready got proto=%0b busy=%0b exp 1/0", protocol_error, busy); end
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clear_reset();
    pulse_clear();
    activate = 2'b01;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      strobe = 1'b1;
      data   = 32'(i);
      @(negedge clk);
    end
    clear = 1'b1;
    data  = 32'd5;
    @(negedge clk);
    clear = 1'b0;
    data  = 32'd0;
    @(negedge clk);
    strobe = 1'b0;
    @(negedge clk);
    checks++; if (total_count !== 32'd1) begin errors++; $display("FAIL clr_total got %0d exp 1", total_count); end
    checks++; if (data_error !== 1'b0 || mismatch_count !== 16'd0 || protocol_error !== 1'b0) begin
      errors++; $display("FAIL clr_errs got %0b/%0d/%0b exp 0/0/0", data_error, mismatch_count, protocol_error); end
    strobe = 1'b1;
    data   = 32'd1;
    @(negedge clk);
    strobe = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (ready !== 2'b00 || busy !== 1'b0 || size !== 24'd2048) begin
      errors++; $display("FAIL arst_state got ready=%0b busy=%0b size=%0d exp 0/0/2048", ready, busy, size); end
    checks++; if (total_count !== 32'd0 || last_xfer_count !== 24'd0) begin
      errors++; $display("FAIL arst_counts got %0d/%0d exp 0/0", total_count, last_xfer_count); end
    activate = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (ready !== 2'b00) begin errors++; $display("FAIL post_rst_ready got %0b exp 00", ready); end
    @(negedge clk);
    checks++; if (ready !== 2'b11) begin errors++; $display("FAIL rst_reoffer got %0b exp 11", ready); end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; clear = 1'b0;
    activate = 2'b00; data = '0; strobe = 1'b0;
    test_reset();
    test_single_burst();
    test_ping_pong();
    test_corruption();
    test_overflow();
    test_handshake();
    test_clear_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppfifo_checker_sink.md
Name: ppfifo_checker_sink

Overview:
- Responder-side model of a ping-pong FIFO write port: the far end of the interface that user-data generators drive (2-bit ready/activate, 24-bit size, 32-bit data, strobe).
- Offers two buffers, accepts bursts into them and simulates the drain back to empty.
- Checks an incrementing data pattern and reports counts and errors to the cocotb bench.
- Used to soak-test generators and user-side adapters without a SATA stack behind them.

Parameters:
BUFFER_DEPTH, 2048, words per buffer; drives the size output (must be 1..2^24-1).
DRAIN_LATENCY, 4, cycles a released buffer stays unavailable before ready re-asserts (>=1).
START_VALUE, 32'h0, first expected data word after reset or clear.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  reset, asynchronous, active-low (0 = reset).
enable  in  1  permit offering empty buffers.
clear  in  1  synchronous pulse: zero counters/error, reload expected value.
ready  out  2  ready[i]=1: buffer i empty and offered.
activate  in  2  initiator owns buffer i while high.
size  out  24  buffer capacity in words.
data  in  32  write data.
strobe  in  1  one word per cycle high.
total_count  out  32  words accepted since reset/clear.
last_xfer_count  out  24  words written in the most recently released buffer.
data_error  out  1  sticky: any pattern mismatch.
mismatch_count  out  16  mismatches; saturates at 16'hFFFF.
first_expected  out  32  expected word at first mismatch.
first_actual  out  32  received word at first mismatch.
protocol_error  out  1  sticky: handshake violation.
busy  out  1  any buffer in OWNED or DRAIN.

Behaviour:
- Reset (rst=0, async): ready=0, size=BUFFER_DEPTH, all counts/captures 0, data_error=0, protocol_error=0, busy=0, expected=START_VALUE, both buffers EMPTY.
- Per-buffer FSM i:
  - EMPTY -> OWNED when activate[i] is sampled high while ready[i]=1.
  - OWNED -> DRAIN on the first cycle activate[i] is sampled low. That cycle: last_xfer_count <= word count of buffer i; drain counter <= DRAIN_LATENCY.
  - DRAIN: decrement; at 1 -> EMPTY.
- ready[i] is registered, = (state_i==EMPTY) && enable. It drops the cycle after activate[i] is sampled high. Both buffers may be offered together.
- enable low blocks new offers only; OWNED/DRAIN buffers complete normally.
- A word is accepted when strobe=1 and exactly one buffer is OWNED with its activate bit high and its word count < BUFFER_DEPTH.
- Accepting a word:
  - compare data with expected;
  - expected <= expected+1 (mod 2^32), whether or not it matched; no resync;
  - total_count += 1 (wraps);
  - buffer word count += 1.
- On a mismatch:
  - data_error <= 1;
  - mismatch_count saturating increment;
  - first_expected/first_actual captured only while mismatch_count==0.
- protocol_error <= 1, word discarded, no counter change, in each of these cases:
  - strobe with no owned active buffer;
  - strobe with the buffer full (count == BUFFER_DEPTH);
  - activate[i] rising while ready[i]=0;
  - activate == 2'b11.
- An activate rising while ready[i]=0 does not change state.
- Activate falling with zero words: legal; last_xfer_count=0; normal DRAIN.
- clear: zeroes counts, errors and captures; expected <= START_VALUE; FSM states untouched. If clear and strobe occur in the same cycle, clear wins and the word is not counted.
- busy = any state != EMPTY (combinational from state registers).
- Reset mid-transfer: everything returns to reset values immediately; ready stays 0 until the first clock edge after release with enable=1.

Test Plan:
- Single burst: enable=1, activate[0] rises, 2048 strobes of 0..2047, release → after DRAIN_LATENCY ready[0]=1; total_count=2048; last_xfer_count=2048; no errors.
- Ping-pong: alternate buffers for 4 bursts of 100 words → total_count=400; ready[i] low exactly from activate sample through 4 drain cycles.
- Corruption: word 10 sent as 32'hDEAD → data_error=1, mismatch_count=1, first_expected=10, first_actual=32'hDEAD; later words still compared against their own index.
- Overflow/orphan: 2049 strobes into one buffer, plus one strobe with no activate → protocol_error=1; total_count=2048.
- Handshake abuse: activate=2'b11, and activate[1] while ready[1]=0 → protocol_error=1; the buffer FSM stays EMPTY.
- Reset/clear: rst=0 mid-burst → all outputs 0 and size=2048 asynchronously. clear with a simultaneous strobe → counts 0; next expected word = START_VALUE.
